// File: rtl/ucs_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ucs_pkg
//  Brief    : Shared state encoding, status codes and defaults for the
//             unsat clause select sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package ucs_pkg;

    localparam int unsigned c_DEFAULT_SELECT_LATENCY = 4;

    localparam int unsigned c_STATE_W = 4;
    localparam logic [c_STATE_W-1:0] c_ST_IDLE    = 4'd0;
    localparam logic [c_STATE_W-1:0] c_ST_SETUP   = 4'd1;
    localparam logic [c_STATE_W-1:0] c_ST_CHECK   = 4'd2;
    localparam logic [c_STATE_W-1:0] c_ST_REQ     = 4'd3;
    localparam logic [c_STATE_W-1:0] c_ST_WAIT    = 4'd4;
    localparam logic [c_STATE_W-1:0] c_ST_OFFER   = 4'd5;
    localparam logic [c_STATE_W-1:0] c_ST_FLIP    = 4'd6;
    localparam logic [c_STATE_W-1:0] c_ST_SETTLE  = 4'd7;
    localparam logic [c_STATE_W-1:0] c_ST_SAT     = 4'd8;
    localparam logic [c_STATE_W-1:0] c_ST_TIMEOUT = 4'd9;
    localparam logic [c_STATE_W-1:0] c_ST_ERROR   = 4'd10;

    localparam logic [1:0] c_STATUS_RUN     = 2'b00;
    localparam logic [1:0] c_STATUS_SAT     = 2'b01;
    localparam logic [1:0] c_STATUS_TIMEOUT = 2'b10;
    localparam logic [1:0] c_STATUS_ERROR   = 2'b11;

    // Quiescent states: selector writes blocked, not busy, start accepted.
    function automatic logic is_quiescent(input logic [c_STATE_W-1:0] st);
        return (st == c_ST_IDLE) || (st == c_ST_SAT) ||
               (st == c_ST_TIMEOUT) || (st == c_ST_ERROR);
    endfunction

    function automatic logic [1:0] status_of(input logic [c_STATE_W-1:0] st);
        case (st)
            c_ST_SAT:     return c_STATUS_SAT;
            c_ST_TIMEOUT: return c_STATUS_TIMEOUT;
            c_ST_ERROR:   return c_STATUS_ERROR;
            default:      return c_STATUS_RUN;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/flip_budget_counter.sv
`default_nettype none
// ============================================================================
//  Module   : flip_budget_counter
//  Brief    : Saturating flip counter with latched flip budget comparison.
//  Revision : 1.0 - initial release
// ============================================================================
module flip_budget_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] budget_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o,
    output logic             expired_o
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_budget;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count  <= '0;
            r_budget <= '0;
        end else if (start_i) begin
            r_count  <= '0;
            r_budget <= budget_i;
        end else if (inc_i && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count_o   = r_count;
    assign expired_o = (r_count == r_budget);

endmodule
`default_nettype wire

// File: rtl/unsat_select_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : unsat_select_sequencer
//  Brief    : Sequences unsat-clause selection requests, offers the selected
//             clause to the flip logic and tracks the flip budget.
//  Revision : 1.0 - initial release
// ============================================================================
module unsat_select_sequencer
    import ucs_pkg::*;
#(
    parameter int unsigned NSAT                  = 3,
    parameter int unsigned LITERAL_ADDRESS_WIDTH = 12,
    parameter int unsigned BUFFER_DEPTH          = 2048,
    parameter int unsigned SELECT_LATENCY        = c_DEFAULT_SELECT_LATENCY,
    parameter int unsigned FLIP_COUNT_WIDTH      = 32
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  start_i,
    input  logic                                  abort_i,
    input  logic                                  load_done_i,
    input  logic [FLIP_COUNT_WIDTH-1:0]           max_flips_i,
    input  logic [$clog2(BUFFER_DEPTH)-1:0]       buffer_count_i,
    input  logic                                  ucb_overflow_i,
    input  logic                                  div_by_zero_i,
    input  logic                                  fifo_empty_i,
    input  logic [NSAT*LITERAL_ADDRESS_WIDTH-1:0] selected_i,
    output logic                                  setup_o,
    output logic                                  request_o,
    output logic                                  write_disable_o,
    output logic                                  clear_debug_o,
    output logic [NSAT*LITERAL_ADDRESS_WIDTH-1:0] clause_o,
    output logic                                  clause_valid_o,
    input  logic                                  clause_ready_i,
    input  logic                                  flip_done_i,
    output logic [FLIP_COUNT_WIDTH-1:0]           flip_count_o,
    output logic [1:0]                            status_o,
    output logic                                  busy_o
);

    localparam int unsigned BUF_ADDR_WIDTH = $clog2(BUFFER_DEPTH);
    localparam int unsigned c_CLAUSE_W     = NSAT * LITERAL_ADDRESS_WIDTH;
    localparam int unsigned c_LAT_W        = $clog2(SELECT_LATENCY + 1);

    logic [c_STATE_W-1:0]  r_state;
    logic [c_STATE_W-1:0]  w_next;
    logic [c_LAT_W-1:0]    r_lat;
    logic                  r_flip_seen;
    logic [c_CLAUSE_W-1:0] r_clause;
    logic                  r_setup;
    logic                  r_request;
    logic                  r_write_disable;
    logic                  r_clear_debug;
    logic                  r_valid;
    logic [1:0]            r_status;
    logic                  r_busy;
    logic                  w_start;
    logic                  w_inc;
    logic                  w_expired;

    assign w_start = is_quiescent(r_state) && start_i && !abort_i;
    // Only the first flip_done of a FLIP visit counts.
    assign w_inc   = (r_state == c_ST_FLIP) && flip_done_i && !r_flip_seen && !abort_i;

    flip_budget_counter #(
        .WIDTH     (FLIP_COUNT_WIDTH)
    ) u_flip_budget_counter (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (w_start),
        .budget_i  (max_flips_i),
        .inc_i     (w_inc),
        .count_o   (flip_count_o),
        .expired_o (w_expired)
    );

    always_comb begin
        w_next = r_state;
        if (abort_i) begin
            w_next = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_SAT, c_ST_TIMEOUT, c_ST_ERROR:
                    if (start_i) w_next = c_ST_SETUP;
                c_ST_SETUP:
                    if (load_done_i) w_next = c_ST_SETTLE;
                c_ST_SETTLE:
                    w_next = c_ST_CHECK;
                c_ST_CHECK:
                    if (ucb_overflow_i)                           w_next = c_ST_ERROR;
                    else if (buffer_count_i == BUF_ADDR_WIDTH'(0)) w_next = c_ST_SAT;
                    else if (w_expired)                           w_next = c_ST_TIMEOUT;
                    else                                          w_next = c_ST_REQ;
                c_ST_REQ:
                    w_next = c_ST_WAIT;
                c_ST_WAIT:
                    if (div_by_zero_i)                w_next = c_ST_ERROR;
                    else if (r_lat == c_LAT_W'(1))    w_next = c_ST_OFFER;
                c_ST_OFFER:
                    if (clause_ready_i) w_next = c_ST_FLIP;
                c_ST_FLIP:
                    if ((flip_done_i || r_flip_seen) && fifo_empty_i) w_next = c_ST_SETTLE;
                default:
                    w_next = c_ST_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they align with r_state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state         <= c_ST_IDLE;
            r_lat           <= '0;
            r_flip_seen     <= 1'b0;
            r_clause        <= '0;
            r_setup         <= 1'b0;
            r_request       <= 1'b0;
            r_write_disable <= 1'b0;
            r_clear_debug   <= 1'b0;
            r_valid         <= 1'b0;
            r_status        <= c_STATUS_RUN;
            r_busy          <= 1'b0;
        end else begin
            r_state         <= w_next;
            r_setup         <= (w_next == c_ST_SETUP);
            r_request       <= (w_next == c_ST_REQ);
            r_valid         <= (w_next == c_ST_OFFER);
            r_write_disable <= is_quiescent(w_next);
            r_busy          <= !is_quiescent(w_next);
            r_status        <= status_of(w_next);
            r_clear_debug   <= w_start;

            if (r_state == c_ST_REQ) begin
                r_lat <= c_LAT_W'(SELECT_LATENCY);
            end else if ((r_state == c_ST_WAIT) && (r_lat != '0)) begin
                r_lat <= r_lat - c_LAT_W'(1);
            end

            if ((r_state == c_ST_WAIT) && (w_next == c_ST_OFFER)) begin
                r_clause <= selected_i;
            end

            if (w_next != c_ST_FLIP) begin
                r_flip_seen <= 1'b0;
            end else if ((r_state == c_ST_FLIP) && flip_done_i) begin
                r_flip_seen <= 1'b1;
            end
        end
    end

    assign setup_o         = r_setup;
    assign request_o       = r_request;
    assign write_disable_o = r_write_disable;
    assign clear_debug_o   = r_clear_debug;
    assign clause_o        = r_clause;
    assign clause_valid_o  = r_valid;
    assign status_o        = r_status;
    assign busy_o          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_unsat_select_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_unsat_select_sequencer
//  Brief    : Directed self-checking bench for unsat_select_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_unsat_select_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i, abort_i, load_done_i;
    logic [31:0] max_flips_i;
    logic [10:0] buffer_count_i;
    logic        ucb_overflow_i, div_by_zero_i, fifo_empty_i;
    logic [35:0] selected_i;
    logic        setup_o, request_o, write_disable_o, clear_debug_o;
    logic [35:0] clause_o;
    logic        clause_valid_o, clause_ready_i, flip_done_i;
    logic [31:0] flip_count_o;
    logic [1:0]  status_o;
    logic        busy_o;

    int n_checks = 0;
    int n_errors = 0;
    int req_count = 0;
    int req_base;

    unsat_select_sequencer dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .load_done_i    (load_done_i),
        .max_flips_i    (max_flips_i),
        .buffer_count_i (buffer_count_i),
        .ucb_overflow_i (ucb_overflow_i),
        .div_by_zero_i  (div_by_zero_i),
        .fifo_empty_i   (fifo_empty_i),
        .selected_i     (selected_i),
        .setup_o        (setup_o),
        .request_o      (request_o),
        .write_disable_o(write_disable_o),
        .clear_debug_o  (clear_debug_o),
        .clause_o       (clause_o),
        .clause_valid_o (clause_valid_o),
        .clause_ready_i (clause_ready_i),
        .flip_done_i    (flip_done_i),
        .flip_count_o   (flip_count_o),
        .status_o       (status_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) if (request_o) req_count = req_count + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_and_load();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        load_done_i = 1'b1;
        tick();
        load_done_i = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!request_o && n < 60) begin tick(); n++; end
        check(tag, 64'(request_o), 64'd1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!clause_valid_o && n < 60) begin tick(); n++; end
        check(tag, 64'(clause_valid_o), 64'd1);
    endtask

    task automatic wait_status(input string tag, input logic [1:0] exp);
        int n = 0;
        while (status_o == 2'b00 && n < 120) begin tick(); n++; end
        check(tag, 64'(status_o), 64'(exp));
    endtask

    initial begin
        int    lat;
        int    n;
        logic  stable;

        rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; load_done_i = 1'b0;
        max_flips_i = 32'd0; buffer_count_i = 11'd0; ucb_overflow_i = 1'b0;
        div_by_zero_i = 1'b0; fifo_empty_i = 1'b0; selected_i = 36'd0;
        clause_ready_i = 1'b0; flip_done_i = 1'b0;
        tick(); tick();
        check("rst_outputs", {setup_o, request_o, write_disable_o, clear_debug_o,
                              clause_valid_o, busy_o, status_o}, 64'd0);
        check("rst_clause", 64'(clause_o), 64'd0);
        check("rst_flips", 64'(flip_count_o), 64'd0);
        rst_i = 1'b0;
        tick();
        check("idle_wdis", 64'(write_disable_o), 64'd1);
        check("idle_busy", 64'(busy_o), 64'd0);

        // Single clause round trip, held ready low, then SAT
        max_flips_i = 32'd100; selected_i = 36'hABC123456; buffer_count_i = 11'd5;
        req_base = req_count;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("setup_hi", 64'(setup_o), 64'd1);
        check("clr_dbg_pulse", 64'(clear_debug_o), 64'd1);
        check("setup_busy_wdis", {busy_o, write_disable_o}, 64'b10);
        load_done_i = 1'b1;
        tick();
        load_done_i = 1'b0;
        check("clr_dbg_one_cycle", {clear_debug_o, setup_o}, 64'd0);
        wait_req("A_req");
        lat = 0;
        do begin tick(); lat++; end while (!clause_valid_o && lat < 20);
        check("A_latency", 64'(lat), 64'd5);
        check("A_clause", 64'(clause_o), 64'hABC123456);
        check("A_one_req", 64'(req_count - req_base), 64'd1);
        selected_i = 36'd0;
        stable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (clause_o !== 36'hABC123456 || clause_valid_o !== 1'b1) stable = 1'b0;
        end
        check("A_offer_stable", 64'(stable), 64'd1);
        clause_ready_i = 1'b1;
        tick();
        clause_ready_i = 1'b0;
        check("A_valid_drop", 64'(clause_valid_o), 64'd0);
        flip_done_i = 1'b1; fifo_empty_i = 1'b0;
        tick();
        flip_done_i = 1'b0;
        tick();
        check("A_flip_count", 64'(flip_count_o), 64'd1);
        fifo_empty_i = 1'b1; buffer_count_i = 11'd0;
        wait_status("A_sat", 2'b01);
        check("A_no_second_req", 64'(req_count - req_base), 64'd1);
        check("A_sat_idle_flags", {busy_o, write_disable_o}, 64'b01);

        // Empty buffer straight after load
        req_base = req_count;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("B_status_cleared", 64'(status_o), 64'd0);
        check("B_flips_cleared", 64'(flip_count_o), 64'd0);
        load_done_i = 1'b1;
        tick();
        load_done_i = 1'b0;
        tick();
        check("B_not_yet", 64'(status_o), 64'd0);
        tick();
        check("B_sat", 64'(status_o), 64'(2'b01));
        check("B_no_req", 64'(req_count - req_base), 64'd0);

        // Budget 3 with immediate handshakes
        selected_i = 36'h000000123; buffer_count_i = 11'd2; max_flips_i = 32'd3;
        clause_ready_i = 1'b1; flip_done_i = 1'b1; fifo_empty_i = 1'b1;
        req_base = req_count;
        start_and_load();
        wait_status("C_timeout", 2'b10);
        check("C_flips", 64'(flip_count_o), 64'd3);
        check("C_reqs", 64'(req_count - req_base), 64'd3);
        check("C_clause", 64'(clause_o), 64'h000000123);

        // Zero budget
        max_flips_i = 32'd0;
        req_base = req_count;
        start_and_load();
        wait_status("Z_timeout", 2'b10);
        check("Z_no_req", 64'(req_count - req_base), 64'd0);
        check("Z_flips", 64'(flip_count_o), 64'd0);
        clause_ready_i = 1'b0; flip_done_i = 1'b0;

        // Divide-by-zero in WAIT cycle 2
        max_flips_i = 32'd100; selected_i = 36'hFFFFFFFFF;
        start_and_load();
        wait_req("D_req");
        tick();
        tick();
        div_by_zero_i = 1'b1;
        tick();
        div_by_zero_i = 1'b0;
        check("D_error", 64'(status_o), 64'(2'b11));
        check("D_no_valid", 64'(clause_valid_o), 64'd0);
        check("D_no_capture", 64'(clause_o), 64'h000000123);

        // Overflow at CHECK
        req_base = req_count;
        ucb_overflow_i = 1'b1;
        start_and_load();
        wait_status("O_error", 2'b11);
        ucb_overflow_i = 1'b0;
        check("O_no_req", 64'(req_count - req_base), 64'd0);

        // Abort in WAIT keeps the flip count
        clause_ready_i = 1'b1; flip_done_i = 1'b1; fifo_empty_i = 1'b1;
        start_and_load();
        n = 0;
        while (flip_count_o != 32'd1 && n < 60) begin tick(); n++; end
        check("E_first_flip", 64'(flip_count_o), 64'd1);
        wait_req("E_req");
        tick();
        abort_i = 1'b1; start_i = 1'b1;
        tick();
        abort_i = 1'b0; start_i = 1'b0;
        check("E_abort_flags", {busy_o, write_disable_o, clause_valid_o, request_o, setup_o}, 64'b01000);
        check("E_abort_status", 64'(status_o), 64'd0);
        check("E_flips_kept", 64'(flip_count_o), 64'd1);

        // Reset while in FLIP
        flip_done_i = 1'b0;
        start_and_load();
        wait_valid("F_valid");
        tick();
        check("F_in_flip", {clause_valid_o, busy_o}, 64'b01);
        rst_i = 1'b1;
        tick();
        check("F_rst_ctrl", {request_o, setup_o, clause_valid_o, busy_o, write_disable_o, clear_debug_o}, 64'd0);
        check("F_rst_data", {clause_o, status_o}, 64'd0);
        check("F_rst_flips", 64'(flip_count_o), 64'd0);
        rst_i = 1'b0; clause_ready_i = 1'b0;
        tick();
        check("F_idle_wdis", 64'(write_disable_o), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/unsat_select_sequencer.md
UNSAT_SELECT_SEQUENCER -- requirements
Module: unsat_select_sequencer

Interface
REQ-001 SHALL have parameter NSAT, default 3, literals per clause.
REQ-002 SHALL have parameter LITERAL_ADDRESS_WIDTH, default 12, literal address width.
REQ-003 SHALL have parameter BUFFER_DEPTH, default 2048 (power of 2); BUF_ADDR_WIDTH = clog2(BUFFER_DEPTH).
REQ-004 SHALL have parameter SELECT_LATENCY, default 4, cycles from request pulse to valid selected clause.
REQ-005 SHALL have parameter FLIP_COUNT_WIDTH, default 32.
REQ-006 SHALL use one clock and a synchronous active-high reset: clk_i input 1 clock; rst_i input 1 reset.
REQ-007 start_i input 1: begin problem load and search.
REQ-008 abort_i input 1: return to IDLE.
REQ-009 load_done_i input 1: unsat-buffer preload finished.
REQ-010 max_flips_i input FLIP_COUNT_WIDTH: flip budget, sampled on start_i.
REQ-011 buffer_count_i input BUF_ADDR_WIDTH: selector unsat count.
REQ-012 ucb_overflow_i input 1: selector count overflow.
REQ-013 div_by_zero_i input 1: selector debug divide-by-zero flag.
REQ-014 fifo_empty_i input 1: newly-unsat clause FIFO empty.
REQ-015 selected_i input NSAT*LITERAL_ADDRESS_WIDTH: selector clause output.
REQ-016 setup_o, request_o, write_disable_o, clear_debug_o output 1 each: selector controls.
REQ-017 clause_o output NSAT*LITERAL_ADDRESS_WIDTH plus clause_valid_o output 1, with clause_ready_i input 1: handshake to flip logic.
REQ-018 flip_done_i input 1: flip logic finished updating FIFO writes.
REQ-019 flip_count_o output FLIP_COUNT_WIDTH; status_o output 2 (00 run/idle, 01 SAT, 10 TIMEOUT, 11 ERROR); busy_o output 1.

Function
REQ-020 SHALL implement states IDLE, SETUP, CHECK, REQ, WAIT, OFFER, FLIP, SETTLE, SAT, TIMEOUT, ERROR.
REQ-021 IDLE/SAT/TIMEOUT/ERROR: start_i -> SETUP; clear_debug_o pulses 1 cycle; flip counter cleared; max_flips_i latched.
REQ-022 SETUP: setup_o=1; load_done_i -> SETTLE.
REQ-023 SETTLE: exactly 1 cycle (lets m-table read follow count) -> CHECK.
REQ-024 CHECK priority: ucb_overflow_i -> ERROR; buffer_count_i==0 -> SAT; flip_count==latched budget -> TIMEOUT; else REQ.
REQ-025 REQ: request_o=1 for exactly one cycle (cycle 0) -> WAIT.
REQ-026 WAIT: selected_i captured into clause_o at end of cycle SELECT_LATENCY; clause_valid_o=1 from cycle SELECT_LATENCY+1 -> OFFER.
REQ-027 WAIT: div_by_zero_i high in any cycle -> ERROR, no capture.
REQ-028 OFFER: clause_valid_o and clause_o held stable until clause_ready_i; transfer on valid&ready -> FLIP; clause_valid_o=0 next cycle.
REQ-029 FLIP: flip_done_i -> flip_count+1 (saturating at all-ones); then wait until fifo_empty_i=1 -> SETTLE. flip_done_i and fifo_empty_i both high in one cycle -> SETTLE directly.
REQ-030 write_disable_o=1 in IDLE, SAT, TIMEOUT, ERROR; 0 otherwise.
REQ-031 busy_o=1 in every state except IDLE, SAT, TIMEOUT, ERROR.
REQ-032 status_o held in terminal state until start_i; 00 otherwise.
REQ-033 abort_i in any state -> IDLE next cycle, overrides start_i and all transitions; flip_count retained.
REQ-034 max_flips_i=0: first CHECK with nonzero count -> TIMEOUT, no request issued.

Reset
REQ-035 rst_i -> IDLE; all outputs 0 (clause_o, flip_count_o, status_o zero); latched budget 0.
REQ-036 rst_i mid-operation SHALL drop request_o/setup_o the following cycle; no partial clause presented.

Structure
REQ-037 State encoding, status codes and default SELECT_LATENCY SHALL live in shared package ucs_pkg.
REQ-038 Latency counter SHALL be a single down-counter sized clog2(SELECT_LATENCY+1); no sub-module needed beyond optional flip_budget_counter.

Verification
REQ-039 Load 5 clauses, budget 100, selected_i=0xABC_123_456 -> request_o 1 cycle, clause_valid_o 5 cycles later, clause_o=0xABC123456.
REQ-040 Load done with buffer_count_i=0 -> SAT (status_o=01) after SETTLE+CHECK, request_o never asserted.
REQ-041 Budget 3, count always 2, ready/flip_done immediate -> exactly 3 requests, status_o=10, flip_count_o=3.
REQ-042 clause_ready_i low 7 cycles in OFFER -> clause_o stable, single transfer, no second request.
REQ-043 div_by_zero_i in WAIT cycle 2 -> ERROR (11); ucb_overflow_i at CHECK -> ERROR.
REQ-044 abort_i in WAIT, then rst_i in FLIP -> IDLE each time, all outputs 0 after reset.
